// File: rtl/display_pkg.sv
// Shared types and segment patterns for the multiplexed result display.
package display_pkg;

    // Segment order is {g,f,e,d,c,b,a}, active low.
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;
    localparam logic [6:0] SEG_DASH  = 7'b011_1111;

    // One history entry: a recognised digit and whether the slot holds one.
    typedef struct packed {
        logic       valid;
        logic [3:0] value;
    } hist_slot_t;

    // Maps a classifier value to its segment pattern; anything above 9 is a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b100_0000;
            4'd1:    pattern = 7'b111_1001;
            4'd2:    pattern = 7'b010_0100;
            4'd3:    pattern = 7'b011_0000;
            4'd4:    pattern = 7'b001_1001;
            4'd5:    pattern = 7'b001_0010;
            4'd6:    pattern = 7'b000_0010;
            4'd7:    pattern = 7'b111_1000;
            4'd8:    pattern = 7'b000_0000;
            4'd9:    pattern = 7'b001_0000;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Digit scan timer: holds each digit for SCAN_DIV cycles and walks the
// scan index round the display, flagging digit advances and frame wraps.
module display_scan_timer #(
    parameter int SCAN_DIV   = 100000,
    parameter int NUM_DIGITS = 4,
    localparam int IDX_W     = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] scan_idx,
    output logic             digit_advance,
    output logic             frame_wrap
);

    localparam int PRE_W = $clog2(SCAN_DIV);

    logic [PRE_W-1:0] prescaler;

    assign digit_advance = (prescaler == PRE_W'(SCAN_DIV - 1));
    assign frame_wrap    = digit_advance && (scan_idx == IDX_W'(NUM_DIGITS - 1));

    // Prescaler and scan index; the index moves on each prescaler terminal count.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            prescaler <= '0;
            scan_idx  <= '0;
        end else if (digit_advance) begin
            prescaler <= '0;
            scan_idx  <= frame_wrap ? '0 : scan_idx + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

endmodule

// File: rtl/result_display_mux.sv
// Keeps a short history of classifier results and time-multiplexes it onto a
// common-anode multi-digit 7-segment display, newest result on digit 0, with a
// decimal-point flash on digit 0 marking a fresh result.
module result_display_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int FLASH_FRAMES = 250
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              result_valid,
    input  logic [3:0]                        result_digit,
    input  logic                              clear,
    output logic [6:0]                        seg,
    output logic [NUM_DIGITS-1:0]             an,
    output logic                              dp,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   history_count
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_W   = $clog2(NUM_DIGITS + 1);
    localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);

    hist_slot_t         slots [NUM_DIGITS];
    logic [FLASH_W-1:0] flash_cnt;
    logic [IDX_W-1:0]   scan_idx;
    logic               digit_advance;
    logic               frame_wrap;

    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;
    logic                  dp_next;
    hist_slot_t            sel_slot;

    display_scan_timer #(
        .SCAN_DIV   (SCAN_DIV),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_scan_timer (
        .clk           (clk),
        .rst           (rst),
        .scan_idx      (scan_idx),
        .digit_advance (digit_advance),
        .frame_wrap    (frame_wrap)
    );

    // History shift register; clear empties it first, so a simultaneous load
    // leaves only the new result in slot 0.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the slot array is small and its valid bits must be known after
        // reset, so it is reset like ordinary registers rather than left as RAM.
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) slots[i] <= '0;
            history_count <= '0;
        end else if (result_valid) begin
            slots[0] <= '{valid: 1'b1, value: result_digit};
            for (int i = 1; i < NUM_DIGITS; i++) slots[i] <= clear ? '0 : slots[i-1];
            if (clear)
                history_count <= CNT_W'(1);
            else if (history_count != CNT_W'(NUM_DIGITS))
                history_count <= history_count + 1'b1;
        end else if (clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) slots[i] <= '0;
            history_count <= '0;
        end
    end

    // Flash counter: reloaded by each new result, counts frame wraps down to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flash_cnt <= '0;
        else if (result_valid)
            flash_cnt <= FLASH_W'(FLASH_FRAMES);
        else if (clear)
            flash_cnt <= '0;
        else if (digit_advance && frame_wrap && flash_cnt != '0)
            flash_cnt <= flash_cnt - 1'b1;
    end

    // Decode the slot selected by the scan index into next-cycle display drive.
    always_comb begin
        // NOTE: every output of this block is given a default first so no path
        // leaves a value held over, which would infer a latch.
        seg_next = SEG_BLANK;
        an_next  = '1;
        dp_next  = 1'b1;
        sel_slot = slots[scan_idx];
        if (sel_slot.valid) seg_next = seg_decode(sel_slot.value);
        an_next = ~(NUM_DIGITS'(1) << scan_idx);
        if (scan_idx == '0 && flash_cnt != '0) dp_next = 1'b0;
    end

    // Output register so seg, an and dp always change together on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= '1;
            dp  <= 1'b1;
        end else begin
            seg <= seg_next;
            an  <= an_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_result_display_mux.sv
// Bench for result_display_mux at SCAN_DIV=4, NUM_DIGITS=4, FLASH_FRAMES=2.
// Stimulus pushes the expected display contents into a scoreboard; a monitor
// pops each entry and compares it digit by digit as the DUT scans.
module tb_result_display_mux;

    localparam logic [6:0] S_BLANK = 7'b111_1111;
    localparam logic [6:0] S_DASH  = 7'b011_1111;
    localparam logic [6:0] S1 = 7'b111_1001;
    localparam logic [6:0] S2 = 7'b010_0100;
    localparam logic [6:0] S3 = 7'b011_0000;
    localparam logic [6:0] S4 = 7'b001_1001;
    localparam logic [6:0] S5 = 7'b001_0010;
    localparam logic [6:0] S6 = 7'b000_0010;
    localparam logic [6:0] S7 = 7'b111_1000;
    localparam logic [6:0] S8 = 7'b000_0000;
    localparam logic [6:0] S9 = 7'b001_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       result_valid = 1'b0;
    logic [3:0] result_digit = 4'd0;
    logic       clear = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic [2:0] history_count;

    always #5 clk = ~clk;

    result_display_mux #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .FLASH_FRAMES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .result_valid  (result_valid),
        .result_digit  (result_digit),
        .clear         (clear),
        .seg           (seg),
        .an            (an),
        .dp            (dp),
        .history_count (history_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard entry: segments for digits 3..0 and the history count.
    typedef struct packed {
        logic [3:0][6:0] segs;
        logic [2:0]      count;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];
    logic  mon_busy = 1'b0;

    // Decimal-point activity, sampled on the falling edge.
    int dp_low   = 0;
    int dp_stray = 0;
    always @(negedge clk) begin
        if (!rst && dp === 1'b0) begin
            dp_low++;
            if (an !== 4'b1110) dp_stray++;
        end
    end

    // Monitor: compares one full scan per scoreboard entry.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (sb_q.size() == 0) continue;
            mon_busy = 1'b1;
            e  = sb_q.pop_front();
            nm = name_q.pop_front();
            @(posedge clk);
            for (int d = 0; d < 4; d++) begin
                logic [3:0] exp_an;
                int waited;
                exp_an = ~(4'b0001 << d);
                waited = 0;
                @(negedge clk);
                while (an !== exp_an && waited < 64) begin
                    @(negedge clk);
                    waited++;
                end
                if (waited >= 64)
                    check($sformatf("%s an digit%0d timeout", nm, d), {28'd0, an}, {28'd0, exp_an});
                else
                    check($sformatf("%s seg digit%0d", nm, d), {25'd0, seg}, {25'd0, e.segs[d]});
            end
            check($sformatf("%s history_count", nm), {29'd0, history_count}, {29'd0, e.count});
            mon_busy = 1'b0;
        end
    end

    // Push an expected display and wait (bounded) until the monitor has checked it.
    task automatic expect_display(input string name, input logic [6:0] d0, input logic [6:0] d1,
                                  input logic [6:0] d2, input logic [6:0] d3, input logic [2:0] cnt);
        exp_t e;
        int   n;
        e.segs  = {d3, d2, d1, d0};
        e.count = cnt;
        sb_q.push_back(e);
        name_q.push_back(name);
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while ((sb_q.size() != 0 || mon_busy) && n < 400);
        if (n >= 400) check({name, " drain timeout"}, 32'd1, 32'd0);
        #1;
    endtask

    // One-cycle pulse; called at posedge+1 and returns at posedge+1.
    task automatic pulse(input logic [3:0] digit, input logic valid, input logic clr);
        result_digit = digit;
        result_valid = valid;
        clear        = clr;
        @(posedge clk);
        #1;
        result_valid = 1'b0;
        clear        = 1'b0;
    endtask

    // Position so that a following pulse lands on the edge that starts digit 0.
    task automatic align_to_frame(input string name);
        logic [3:0] prev;
        bit found;
        found = 0;
        prev  = an;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an == 4'b0111 && prev != 4'b0111) found = 1;
            prev = an;
        end
        if (!found) check({name, " align timeout"}, {28'd0, an}, 32'h7);
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int waited;

        // Reset state while held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset seg", {25'd0, seg}, 32'h7F);
        check("reset an", {28'd0, an}, 32'hF);
        check("reset dp", {31'd0, dp}, 32'd1);
        check("reset history_count", {29'd0, history_count}, 32'd0);

        // Release and watch the anode scan: 4 clk per digit, all blank.
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] exp_an;
            exp_an = ~(4'b0001 << ((k - 1) / 4));
            @(negedge clk);
            check($sformatf("scan an cycle%0d", k), {28'd0, an}, {28'd0, exp_an});
            check($sformatf("scan seg cycle%0d", k), {25'd0, seg}, 32'h7F);
        end
        @(posedge clk);
        #1;

        // History shift: oldest value falls off.
        pulse(4'd3, 1, 0);
        pulse(4'd7, 1, 0);
        pulse(4'd1, 1, 0);
        pulse(4'd9, 1, 0);
        pulse(4'd5, 1, 0);
        expect_display("history", S5, S9, S1, S7, 3'd4);

        // Flash: exactly two digit-0 windows of 4 cycles.
        pulse(4'd0, 0, 1);
        expect_display("clear1", S_BLANK, S_BLANK, S_BLANK, S_BLANK, 3'd0);
        base = dp_low;
        align_to_frame("flash");
        pulse(4'd2, 1, 0);
        idle(60);
        check("flash dp low cycles", dp_low - base, 32'd8);
        expect_display("flash digits", S2, S_BLANK, S_BLANK, S_BLANK, 3'd1);

        // Flash restart: second result one frame in.
        idle(40);
        base = dp_low;
        align_to_frame("restart1");
        pulse(4'd6, 1, 0);
        align_to_frame("restart2");
        pulse(4'd6, 1, 0);
        idle(60);
        check("flash restart dp low cycles", dp_low - base, 32'd12);
        check("dp only on digit 0", dp_stray, 32'd0);
        expect_display("restart digits", S6, S6, S2, S_BLANK, 3'd3);

        // Clear with a full history; no flash afterwards.
        pulse(4'd1, 1, 0);
        pulse(4'd2, 1, 0);
        pulse(4'd3, 1, 0);
        pulse(4'd4, 1, 0);
        expect_display("full", S4, S3, S2, S1, 3'd4);
        pulse(4'd0, 0, 1);
        idle(1);
        base = dp_low;
        idle(40);
        check("dp idle after clear", dp_low - base, 32'd0);
        expect_display("cleared", S_BLANK, S_BLANK, S_BLANK, S_BLANK, 3'd0);

        // Clear and load together: only the new value, flash restarted.
        idle(40);
        base = dp_low;
        align_to_frame("clear+load");
        pulse(4'd8, 1, 1);
        idle(60);
        check("clear+load dp low cycles", dp_low - base, 32'd8);
        expect_display("clear+load", S8, S_BLANK, S_BLANK, S_BLANK, 3'd1);

        // Out-of-range value shows a dash.
        pulse(4'd12, 1, 0);
        expect_display("dash", S_DASH, S8, S_BLANK, S_BLANK, 3'd2);

        // Back-to-back pulses each shift once.
        pulse(4'd0, 0, 1);
        result_valid = 1'b1;
        result_digit = 4'd4;
        @(posedge clk); #1;
        result_digit = 4'd5;
        @(posedge clk); #1;
        result_digit = 4'd6;
        @(posedge clk); #1;
        result_valid = 1'b0;
        expect_display("back-to-back", S6, S5, S4, S_BLANK, 3'd3);

        // Asynchronous reset mid-flash while digit 2 is driven.
        pulse(4'd7, 1, 0);
        waited = 0;
        @(negedge clk);
        while (an !== 4'b1011 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("digit2 reached before reset", {28'd0, an}, 32'hB);
        #2;
        rst = 1'b1;
        #1;
        check("async reset seg", {25'd0, seg}, 32'h7F);
        check("async reset an", {28'd0, an}, 32'hF);
        check("async reset dp", {31'd0, dp}, 32'd1);
        check("async reset history_count", {29'd0, history_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        expect_display("after async reset", S_BLANK, S_BLANK, S_BLANK, S_BLANK, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
